l2_sched: RTL and testbench



---
 rtl/l2_pkg.sv | 37 +++
 rtl/l2_win_addr.sv | 111 +++++++++++
 rtl/l2_sched.sv | 148 ++++++++++++++
 tb/tb_l2_sched.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_pkg.sv
// l2_pkg: definitions shared by the layer-2 sequencer and its window-address
// generator.
//   - default geometry of the layer-1 feature map and kernel
//   - derived constants: N_TAP, OUT_W, OUT_H, N_PIX
//   - tap data width DW
//   - FSM state type and state encodings
package l2_pkg;

  localparam int DW = 18;

  localparam int DEF_IN_W = 12;
  localparam int DEF_IN_H = 12;
  localparam int DEF_KW   = 2;
  localparam int DEF_KH   = 5;
  localparam int DEF_AW   = 8;

  // Size of a "valid" convolution output along one axis.
  function automatic int out_dim(input int in_d, input int k_d);
    return in_d - k_d + 1;
  endfunction

  localparam int N_TAP = DEF_KH * DEF_KW;
  localparam int OUT_W = out_dim(DEF_IN_W, DEF_KW);
  localparam int OUT_H = out_dim(DEF_IN_H, DEF_KH);
  localparam int N_PIX = OUT_W * OUT_H;

  typedef logic [2:0] l2_sched_state_t;

  localparam l2_sched_state_t S_IDLE    = 3'd0;
  localparam l2_sched_state_t S_WAIT_L1 = 3'd1;
  localparam l2_sched_state_t S_ISSUE   = 3'd2;
  localparam l2_sched_state_t S_TAPS    = 3'd3;
  localparam l2_sched_state_t S_DRAIN   = 3'd4;
  localparam l2_sched_state_t S_WAIT_DS = 3'd5;
  localparam l2_sched_state_t S_DONE    = 3'd6;

endpackage

// File: rtl/l2_win_addr.sv
// l2_win_addr: incremental window-address generator for the layer-1 buffer.
// The address of tap k of the current output pixel is base + offset, where
// base tracks the top-left corner of the window (+1 per column, +KW at a row
// wrap) and offset tracks the tap position inside the kernel (+1 along a
// kernel row, +IN_W-KW+1 when stepping down a kernel row). No multiplier.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return every counter to 0 (end of image)
//   tap_go     : current tap address consumed, step to the next tap
//   pix_adv    : step to the next output pixel (raster order)
//   addr       : base + offset of the current tap
//   pix_idx    : index of the current output pixel
//   tap_last   : current tap is the last one of the kernel
//   pix_last   : current pixel is the last one of the image
module l2_win_addr
  import l2_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int IN_H = DEF_IN_H,
  parameter int KW   = DEF_KW,
  parameter int KH   = DEF_KH,
  parameter int AW   = DEF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          tap_go,
  input  logic          pix_adv,
  output logic [AW-1:0] addr,
  output logic [7:0]    pix_idx,
  output logic          tap_last,
  output logic          pix_last
);

  localparam int NT  = KH * KW;
  localparam int OW  = out_dim(IN_W, KW);
  localparam int OH  = out_dim(IN_H, KH);
  localparam int CW  = (OW > 1) ? $clog2(OW) : 1;
  localparam int RW  = (OH > 1) ? $clog2(OH) : 1;
  localparam int KXW = (KW > 1) ? $clog2(KW) : 1;
  localparam int KNW = (NT > 1) ? $clog2(NT) : 1;

  logic [AW-1:0]  base_reg;
  logic [AW-1:0]  off_reg;
  logic [CW-1:0]  col_reg;
  logic [RW-1:0]  row_reg;
  logic [KXW-1:0] kx_reg;
  logic [KNW-1:0] k_reg;
  logic [7:0]     pix_reg;

  assign addr     = base_reg + off_reg;
  assign pix_idx  = pix_reg;
  assign tap_last = (k_reg == KNW'(NT - 1));
  assign pix_last = (row_reg == RW'(OH - 1)) && (col_reg == CW'(OW - 1));

  // Tap walk: k/kx/offset return to tap 0 after the last tap so the next
  // pixel starts from a clean window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_reg   <= '0;
      kx_reg  <= '0;
      off_reg <= '0;
    end else if (clr) begin
      k_reg   <= '0;
      kx_reg  <= '0;
      off_reg <= '0;
    end else if (tap_go) begin
      if (tap_last) begin
        k_reg   <= '0;
        kx_reg  <= '0;
        off_reg <= '0;
      end else begin
        k_reg <= k_reg + KNW'(1);
        if (kx_reg == KXW'(KW - 1)) begin
          kx_reg  <= '0;
          off_reg <= off_reg + AW'(IN_W - KW + 1);
        end else begin
          kx_reg  <= kx_reg + KXW'(1);
          off_reg <= off_reg + AW'(1);
        end
      end
    end
  end

  // Pixel raster walk. At a row wrap the window corner jumps from column
  // OW-1 = IN_W-KW of one row to column 0 of the next: a step of KW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_reg <= '0;
      col_reg  <= '0;
      row_reg  <= '0;
      pix_reg  <= '0;
    end else if (clr) begin
      base_reg <= '0;
      col_reg  <= '0;
      row_reg  <= '0;
      pix_reg  <= '0;
    end else if (pix_adv) begin
      pix_reg <= pix_reg + 8'd1;
      if (col_reg == CW'(OW - 1)) begin
        col_reg  <= '0;
        row_reg  <= row_reg + RW'(1);
        base_reg <= base_reg + AW'(KW);
      end else begin
        col_reg  <= col_reg + CW'(1);
        base_reg <= base_reg + AW'(1);
      end
    end
  end

endmodule

// File: rtl/l2_sched.sv
// l2_sched: sequencer for the layer-2 convolution datapath. Walks the output
// pixels of one image, fetches the layer-1 window taps of each pixel and
// streams them to layer 2 in lock-step with its accumulation window.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   img_strt, abort     : one-cycle image start / cancel requests
//   l1_full             : layer-1 buffer holds a complete image
//   l1_addr             : layer-1 read address (1-cycle read latency)
//   l1_din_0, l1_din_1  : layer-1 read data, channels 0/1
//   l2_strt             : layer-2 pixel start pulse
//   l2_din_0, l2_din_1  : tap data to layer 2, zero outside the tap window
//   l2_bsy              : layer 2 accumulating
//   ds_done             : downstream consumed all layer-2 outputs
//   tx_done             : one-cycle end-of-image pulse
//   sched_bsy           : image in progress
//   pix_idx             : index of the pixel currently issued
module l2_sched
  import l2_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int IN_H = DEF_IN_H,
  parameter int KW   = DEF_KW,
  parameter int KH   = DEF_KH,
  parameter int AW   = DEF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          img_strt,
  input  logic          abort,
  input  logic          l1_full,
  output logic [AW-1:0] l1_addr,
  input  logic [DW-1:0] l1_din_0,
  input  logic [DW-1:0] l1_din_1,
  output logic          l2_strt,
  output logic [DW-1:0] l2_din_0,
  output logic [DW-1:0] l2_din_1,
  input  logic          l2_bsy,
  input  logic          ds_done,
  output logic          tx_done,
  output logic          sched_bsy,
  output logic [7:0]    pix_idx
);

  localparam int OW = out_dim(IN_W, KW);
  localparam int OH = out_dim(IN_H, KH);
  localparam int NP = OW * OH;

  // Layer 2 writes its results with a 7-bit address.
  generate
    if (NP > 128) begin : g_npix_chk
      $error("l2_sched: output pixel count exceeds layer-2 write range");
    end
    if (IN_W * IN_H > (1 << AW)) begin : g_aw_chk
      $error("l2_sched: AW too narrow for the layer-1 feature map");
    end
  endgenerate

  l2_sched_state_t state_reg, state_next;
  logic            tap_valid_reg;

  logic            abort_act;
  logic            issue_fire;
  logic            tap_go;
  logic            pix_adv;
  logic            win_clr;
  logic            tap_on;
  logic [AW-1:0]   win_addr;
  logic            tap_last;
  logic            pix_last;

  // DONE is already on its way out; a late abort must not stretch tx_done.
  assign abort_act  = abort && (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign issue_fire = (state_reg == S_ISSUE) && !l2_bsy && !abort_act;
  assign tap_go     = issue_fire || (state_reg == S_TAPS);
  assign pix_adv    = (state_reg == S_DRAIN) && !l2_bsy && !pix_last && !abort_act;
  assign win_clr    = (state_reg == S_DONE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (img_strt) state_next = S_WAIT_L1;
      S_WAIT_L1: if (l1_full)  state_next = S_ISSUE;
      S_ISSUE:   if (!l2_bsy)  state_next = S_TAPS;
      S_TAPS:    if (tap_last) state_next = S_DRAIN;
      S_DRAIN:   if (!l2_bsy)  state_next = pix_last ? S_WAIT_DS : S_ISSUE;
      S_WAIT_DS: if (ds_done)  state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    if (abort_act) state_next = S_DONE;
  end

  // tap_valid_reg marks the cycle in which the read issued one cycle earlier
  // returns; that is exactly the layer-2 accumulation window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      tap_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tap_valid_reg <= tap_go && !abort_act;
    end
  end

  l2_win_addr #(
    .IN_W (IN_W),
    .IN_H (IN_H),
    .KW   (KW),
    .KH   (KH),
    .AW   (AW)
  ) u_win_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (win_clr),
    .tap_go   (tap_go),
    .pix_adv  (pix_adv),
    .addr     (win_addr),
    .pix_idx  (pix_idx),
    .tap_last (tap_last),
    .pix_last (pix_last)
  );

  assign l1_addr   = tap_go ? win_addr : '0;
  assign l2_strt   = issue_fire;
  assign tx_done   = (state_reg == S_DONE);
  assign sched_bsy = (state_reg != S_IDLE);

  // Layer 2 accumulates every cycle, so anything outside the tap window
  // (and the returning read in an abort cycle) is forced to zero.
  assign tap_on = tap_valid_reg && !abort_act;

  logic [DW-1:0] din_arr [2];
  logic [DW-1:0] dout_arr[2];

  assign din_arr[0] = l1_din_0;
  assign din_arr[1] = l1_din_1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_gate
      assign dout_arr[gi] = tap_on ? din_arr[gi] : '0;
    end
  endgenerate

  assign l2_din_0 = dout_arr[0];
  assign l2_din_1 = dout_arr[1];

endmodule

// File: tb/tb_l2_sched.sv
// tb_l2_sched: self-checking bench for l2_sched. A control-sequence table
// opens the first image; a cycle monitor then checks every pixel against a
// reference built from the window formulas (addr = (row+ky)*IN_W + col+kx),
// a layer-1 memory model and a layer-2 busy model; hand-written sequences
// cover back-pressure, row wrap, abort and asynchronous reset.
module tb_l2_sched;

  localparam int B_IN_W = 12;
  localparam int B_IN_H = 12;
  localparam int B_KW   = 2;
  localparam int B_KH   = 5;
  localparam int B_OW   = B_IN_W - B_KW + 1;
  localparam int B_OH   = B_IN_H - B_KH + 1;
  localparam int B_NTAP = B_KW * B_KH;
  localparam int B_NPIX = B_OW * B_OH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        img_strt = 1'b0;
  logic        abort = 1'b0;
  logic        l1_full = 1'b0;
  logic [7:0]  l1_addr;
  logic [17:0] l1_din_0 = '0;
  logic [17:0] l1_din_1 = '0;
  logic        l2_strt;
  logic [17:0] l2_din_0;
  logic [17:0] l2_din_1;
  logic        l2_bsy = 1'b0;
  logic        ds_done = 1'b0;
  logic        tx_done;
  logic        sched_bsy;
  logic [7:0]  pix_idx;

  always #5 clk = ~clk;

  l2_sched #(
    .IN_W (B_IN_W),
    .IN_H (B_IN_H),
    .KW   (B_KW),
    .KH   (B_KH),
    .AW   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .img_strt  (img_strt),
    .abort     (abort),
    .l1_full   (l1_full),
    .l1_addr   (l1_addr),
    .l1_din_0  (l1_din_0),
    .l1_din_1  (l1_din_1),
    .l2_strt   (l2_strt),
    .l2_din_0  (l2_din_0),
    .l2_din_1  (l2_din_1),
    .l2_bsy    (l2_bsy),
    .ds_done   (ds_done),
    .tx_done   (tx_done),
    .sched_bsy (sched_bsy),
    .pix_idx   (pix_idx)
  );

  int total = 0;
  int bad   = 0;

  // Next-cycle input values, applied just after the rising edge by tick().
  logic nx_img = 1'b0, nx_abort = 1'b0, nx_full = 1'b0, nx_ds = 1'b0;

  logic [17:0] mem0 [256];
  logic [17:0] mem1 [256];

  int          addr_q[$];
  logic [35:0] dat_q[$];
  int          mdl_pix = 0;
  int          strt_cnt = 0;
  int          tx_cnt = 0;
  int          cyc = 0;
  int          bsy_cnt = 0;
  int          last_strt_pix = -1;
  int          strt_cyc[128];
  int          ex[128];
  logic [7:0]  prev_addr = '0;

  typedef struct packed {
    logic img;
    logic abt;
    logic full;
    logic ds;
    logic e_bsy;
    logic e_tx;
    logic e_strt;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int ref_addr(input int p, input int k);
    return (p / B_OW + k / B_KW) * B_IN_W + (p % B_OW) + (k % B_KW);
  endfunction

  task automatic new_image();
    strt_cnt = 0;
    for (int p = 0; p < 128; p++) begin
      if (p == 0)      ex[p] = 0;
      else if (p == 3) ex[p] = 5;
      else             ex[p] = $urandom_range(0, 3);
    end
  endtask

  task automatic monitor();
    logic [35:0] d;
    int a;
    if (abort) begin
      addr_q.delete();
      dat_q.delete();
    end
    if (dat_q.size() > 0) begin
      d = dat_q.pop_front();
      check("tap_data", {l2_din_0, l2_din_1}, d);
    end else begin
      check("idle_data_zero", {l2_din_0, l2_din_1}, 36'd0);
    end
    if (addr_q.size() > 0) begin
      a = addr_q.pop_front();
      check("tap_addr", l1_addr, a);
    end
    if (l2_strt) begin
      check("strt_while_bsy", l2_bsy, 0);
      check("strt_overlap", dat_q.size(), 0);
      check("strt_in_range", mdl_pix < B_NPIX, 1);
      check("strt_pix_idx", pix_idx, mdl_pix);
      check("tap0_addr", l1_addr, ref_addr(mdl_pix, 0));
      for (int k = 1; k < B_NTAP; k++) addr_q.push_back(ref_addr(mdl_pix, k));
      for (int k = 0; k < B_NTAP; k++)
        dat_q.push_back({mem0[ref_addr(mdl_pix, k)], mem1[ref_addr(mdl_pix, k)]});
      $display("pix %0d start at cycle %0d addr %0d", mdl_pix, cyc, l1_addr);
      if (mdl_pix < 128) begin
        strt_cyc[mdl_pix] = cyc;
        bsy_cnt = B_NTAP + ex[mdl_pix];
      end
      last_strt_pix = mdl_pix;
      mdl_pix++;
      strt_cnt++;
    end else if (bsy_cnt > 0) begin
      bsy_cnt--;
    end
    if (tx_done) begin
      tx_cnt++;
      mdl_pix = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    img_strt = nx_img;
    abort    = nx_abort;
    l1_full  = nx_full;
    ds_done  = nx_ds;
    l1_din_0 = mem0[prev_addr];
    l1_din_1 = mem1[prev_addr];
    l2_bsy   = (bsy_cnt > 0);
    @(negedge clk);
    cyc++;
    prev_addr = l1_addr;
    if (rst_n) monitor();
  endtask

  task automatic wait_strt(input int p);
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (l2_strt === 1'b1 && last_strt_pix == p) return;
    end
    check("wait_strt_timeout", 0, 1);
  endtask

  task automatic start_image();
    new_image();
    nx_img = 1'b1;
    tick();
    nx_img = 1'b0;
  endtask

  task automatic end_image();
    int tx0;
    tx0 = tx_cnt;
    for (int n = 0; n < 30; n++) tick();
    check("no_tx_before_ds", tx_cnt, tx0);
    check("bsy_in_wait_ds", sched_bsy, 1);
    check("strt_count", strt_cnt, B_NPIX);
    nx_ds = 1'b1;
    tick();
    check("tx_on_ds_cycle", tx_done, 0);
    nx_ds = 1'b0;
    tick();
    check("tx_done_pulse", tx_done, 1);
    tick();
    check("tx_done_single", tx_done, 0);
    check("idle_after_done", sched_bsy, 0);
    check("pix_idx_cleared", pix_idx, 0);
  endtask

  initial begin
    int seq[10];
    seq = '{0, 1, 12, 13, 24, 25, 36, 37, 48, 49};
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 18'($urandom) | 18'h1;
      mem1[i] = 18'($urandom) | 18'h2;
    end

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_l1_addr", l1_addr, 0);
    check("rst_l2_strt", l2_strt, 0);
    check("rst_l2_din", {l2_din_0, l2_din_1}, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_sched_bsy", sched_bsy, 0);
    check("rst_pix_idx", pix_idx, 0);
    rst_n = 1'b1;

    // Image 1: control prologue from the table, then a full image.
    new_image();
    //          img  abt  full ds   bsy  tx   strt
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      nx_img   = tbl[i].img;
      nx_abort = tbl[i].abt;
      nx_full  = tbl[i].full;
      nx_ds    = tbl[i].ds;
      tick();
      check($sformatf("vec%0d_sched_bsy", i), sched_bsy, tbl[i].e_bsy);
      check($sformatf("vec%0d_tx_done", i), tx_done, tbl[i].e_tx);
      check($sformatf("vec%0d_l2_strt", i), l2_strt, tbl[i].e_strt);
    end
    nx_img = 1'b0; nx_abort = 1'b0; nx_ds = 1'b0; nx_full = 1'b1;
    check("pix0_first_addr", l1_addr, seq[0]);
    for (int k = 1; k < 10; k++) begin
      tick();
      check($sformatf("pix0_tap%0d_addr", k), l1_addr, seq[k]);
    end
    wait_strt(1);
    check("pixel_period", strt_cyc[1] - strt_cyc[0], 12);
    wait_strt(4);
    check("backpressure_gap", strt_cyc[4] - strt_cyc[3], 17);
    wait_strt(10);
    check("row_end_addr", l1_addr, 10);
    wait_strt(11);
    check("row_wrap_addr", l1_addr, 12);
    wait_strt(87);
    repeat (9) tick();
    check("last_tap_addr", l1_addr, 143);
    end_image();

    // Image 2: abort at pixel 40, tap 5.
    start_image();
    wait_strt(40);
    repeat (4) tick();
    nx_abort = 1'b1;
    tick();
    check("abort_tap5_addr", l1_addr, 68);
    check("abort_data_zero", {l2_din_0, l2_din_1}, 0);
    nx_abort = 1'b0;
    tick();
    check("abort_tx_done", tx_done, 1);
    check("abort_next_data_zero", {l2_din_0, l2_din_1}, 0);
    tick();
    check("abort_tx_single", tx_done, 0);
    check("abort_idle", sched_bsy, 0);
    check("abort_pix_cleared", pix_idx, 0);

    // Image 3: restart after abort, then asynchronous reset mid-taps.
    start_image();
    wait_strt(0);
    check("restart_addr", l1_addr, 0);
    check("restart_pix", pix_idx, 0);
    wait_strt(2);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_l1_addr", l1_addr, 0);
    check("arst_l2_din", {l2_din_0, l2_din_1}, 0);
    check("arst_pix_idx", pix_idx, 0);
    check("arst_sched_bsy", sched_bsy, 0);
    check("arst_tx_done", tx_done, 0);
    addr_q.delete();
    dat_q.delete();
    mdl_pix = 0;
    bsy_cnt = 0;
    for (int n = 0; n < 2; n++) begin
      tick();
      check("arst_no_tx", tx_done, 0);
      check("arst_no_strt", l2_strt, 0);
    end
    rst_n = 1'b1;

    // Image 4: normal run after reset release.
    start_image();
    wait_strt(0);
    check("post_rst_addr", l1_addr, 0);
    wait_strt(87);
    end_image();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
